// File: rtl/rv_isa_pkg.sv
// RV32I ISA constants for the instruction-memory loader: opcodes, immediate
// format codes (aligned with the core's decode ImmSel codes), the canonical
// NOP, the loader FSM states and an opcode-to-format decode helper.
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_R     = 3'b000,
    FMT_I     = 3'b001,
    FMT_S     = 3'b010,
    FMT_B     = 3'b011,
    FMT_J     = 3'b100,
    FMT_LUI   = 3'b101,
    FMT_AUIPC = 3'b110
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic legal;
    fmt_e fmt;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [6:0] op);
    op_dec_t d;
    d.legal = 1'b1;
    d.fmt   = FMT_R;
    case (op)
      OP_R:                     d.fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: d.fmt = FMT_I;
      OP_STORE:                 d.fmt = FMT_S;
      OP_BRANCH:                d.fmt = FMT_B;
      OP_JAL:                   d.fmt = FMT_J;
      OP_LUI:                   d.fmt = FMT_LUI;
      OP_AUIPC:                 d.fmt = FMT_AUIPC;
      default:                  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field packer: turns an opcode/funct/register/immediate
// bundle into a 32-bit instruction word. Unsupported opcodes produce the NOP
// and raise o_illegal. Optional macro IMM_RANGE_CHECK_EN adds o_imm_err for
// immediates that do not survive truncation into their field.
module rv_instr_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal,
  output logic        o_imm_err
);

  op_dec_t    w_dec;
  logic [2:0] w_f3;

  assign w_dec     = decode_op(i_opcode);
  assign w_f3      = (i_opcode == OP_JALR) ? 3'b000 : i_funct3;
  assign o_illegal = !w_dec.legal;

  // Scatter the fields into the word according to the instruction format
  always_comb begin
    o_word = INSTR_NOP;
    if (w_dec.legal) begin
      case (w_dec.fmt)
        FMT_R:   o_word = {i_funct7, i_rs2, i_rs1, w_f3, i_rd, i_opcode};
        FMT_I:   o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, i_opcode};
        FMT_S:   o_word = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], i_opcode};
        FMT_B:   o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                           i_imm[4:1], i_imm[11], i_opcode};
        FMT_J:   o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                           i_rd, i_opcode};
        default: o_word = {i_imm[31:12], i_rd, i_opcode};
      endcase
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  // True when v is a sign extension of its low (top+1) bits.
  function automatic logic fits_signed(input logic [31:0] v, input int top);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    s  = v;
    hi = s >>> top;
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

  // Flag immediates whose bits fall outside the encodable field
  always_comb begin
    o_imm_err = 1'b0;
    if (w_dec.legal) begin
      case (w_dec.fmt)
        FMT_I, FMT_S:       o_imm_err = !fits_signed(i_imm, 11);
        FMT_B:              o_imm_err = !fits_signed(i_imm, 12) || i_imm[0];
        FMT_J:              o_imm_err = !fits_signed(i_imm, 20) || i_imm[0];
        FMT_LUI, FMT_AUIPC: o_imm_err = (i_imm[11:0] != 12'd0);
        default:            o_imm_err = 1'b0;
      endcase
    end
  end
`else
  logic w_unused_imm0;
  assign w_unused_imm0 = i_imm[0];
  assign o_imm_err     = 1'b0;
`endif

endmodule

// File: rtl/rv_instr_encode_loader.sv
// Instruction-memory loader: accepts RV32I field bundles on a valid/ready
// stream, packs them into instruction words and writes them to consecutive
// word addresses from a latched base. One-entry output register keeps the
// write port stable under backpressure while sustaining one word per cycle.
// Optional macro IMM_RANGE_CHECK_EN enables the sticky err_imm flag.
module rv_instr_encode_loader
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_imm
);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_start_ok;
  logic              w_busy;
  logic              w_done;

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_accepted;
  logic [CNT_W-1:0]  r_written;
  logic [ADDR_W-1:0] r_next_addr;

  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [31:0]       r_wdata_p1;
  logic              r_err_illegal;
  logic              r_err_imm;

  logic [31:0]       w_word_p0;
  logic              w_illegal_p0;
  logic              w_imm_err_p0;
  logic              w_accept;
  logic              w_hs;
  logic              w_last_hs;

  rv_instr_pack u_pack (
    .i_opcode  (opcode),
    .i_funct3  (funct3),
    .i_funct7  (funct7),
    .i_rd      (rd),
    .i_rs1     (rs1),
    .i_rs2     (rs2),
    .i_imm     (imm),
    .o_word    (w_word_p0),
    .o_illegal (w_illegal_p0),
    .o_imm_err (w_imm_err_p0)
  );

  // Accept while words remain and the output register is free or draining
  assign in_ready  = (r_state == ST_RUN) && (r_accepted < r_count) && (!r_vld_p1 || imem_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_hs      = r_vld_p1 && imem_ready;
  assign w_last_hs = w_hs && (r_written == (r_count - CNT_W'(1)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start_ok = start;
        if (start) w_next_state = (count == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last_hs) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: latch job parameters, register packed word, track progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= '0;
      r_accepted    <= '0;
      r_written     <= '0;
      r_next_addr   <= '0;
      r_vld_p1      <= 1'b0;
      r_addr_p1     <= '0;
      r_wdata_p1    <= '0;
      r_err_illegal <= 1'b0;
      r_err_imm     <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_count       <= count;
        r_accepted    <= '0;
        r_written     <= '0;
        r_next_addr   <= base_addr;
        r_err_illegal <= 1'b0;
        r_err_imm     <= 1'b0;
      end
      if (w_accept) begin
        r_accepted    <= r_accepted + CNT_W'(1);
        r_next_addr   <= r_next_addr + ADDR_W'(4);
        r_addr_p1     <= r_next_addr;
        r_wdata_p1    <= w_word_p0;
        r_err_illegal <= r_err_illegal | w_illegal_p0;
        r_err_imm     <= r_err_imm | w_imm_err_p0;
      end
      if (w_hs) r_written <= r_written + CNT_W'(1);
      if (w_accept)  r_vld_p1 <= 1'b1;
      else if (w_hs) r_vld_p1 <= 1'b0;
    end
  end

  assign imem_we     = r_vld_p1;
  assign imem_addr   = r_addr_p1;
  assign imem_wdata  = r_wdata_p1;
  assign busy        = w_busy;
  assign done        = w_done;
  assign err_illegal = r_err_illegal;
  assign err_imm     = r_err_imm;

endmodule
